// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath widths and the combinational ALU.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_SLT  = 4'h2;
    localparam logic [OP_W-1:0] OP_SLTU = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_OR   = 4'h5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
    localparam logic [OP_W-1:0] OP_NOR  = 4'h7;
    localparam logic [OP_W-1:0] OP_SLL  = 4'h8;
    localparam logic [OP_W-1:0] OP_SRL  = 4'h9;
    localparam logic [OP_W-1:0] OP_SRA  = 4'hA;
    localparam logic [OP_W-1:0] OP_SLLV = 4'hB;
    localparam logic [OP_W-1:0] OP_SRLV = 4'hC;
    localparam logic [OP_W-1:0] OP_SRAV = 4'hD;
    localparam logic [OP_W-1:0] OP_LUI  = 4'hE;

    // Immediate shifts use shamt; variable shifts take the amount from a[4:0].
    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [OP_W-1:0]    op,
        input logic [DATA_W-1:0]  a,
        input logic [DATA_W-1:0]  b,
        input logic [SHAMT_W-1:0] shamt
    );
        logic [DATA_W-1:0]  r;
        logic [SHAMT_W-1:0] va;
        r  = '0;
        va = a[SHAMT_W-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = DATA_W'($signed(a) < $signed(b));
            OP_SLTU: r = DATA_W'(a < b);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLL:  r = b << shamt;
            OP_SRL:  r = b >> shamt;
            OP_SRA:  r = DATA_W'($signed(b) >>> shamt);
            OP_SLLV: r = b << va;
            OP_SRLV: r = b >> va;
            OP_SRAV: r = DATA_W'($signed(b) >>> va);
            OP_LUI:  r = {b[15:0], 16'h0000};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way grant picker: round-robin against last_grant, optional strict priority for port 0.
module alu_rr_pick (
    input  logic [1:0] elig,
    input  logic       last_grant,
    input  logic       prio0,
    output logic [1:0] grant
);

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = (prio0 || last_grant) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the EX stage (port 0) and an auxiliary sequencer (port 1)
// with per-port registered results held until consumed.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter bit          PRIO0 = 1'b1,
    parameter int unsigned TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0][DATA_W-1:0]       req_a,
    input  logic [1:0][DATA_W-1:0]       req_b,
    input  logic [1:0][OP_W-1:0]         req_op,
    input  logic [1:0][SHAMT_W-1:0]      req_shamt,
    input  logic [1:0][TAG_W-1:0]        req_tag,
    output logic [1:0]                   rsp_valid,
    input  logic [1:0]                   rsp_ready,
    output logic [1:0][DATA_W-1:0]       rsp_data,
    output logic [1:0][TAG_W-1:0]        rsp_tag,
    output logic                         last_grant
);

    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [1:0][DATA_W-1:0]  rsp_data_q,  rsp_data_d;
    logic [1:0][TAG_W-1:0]   rsp_tag_q,   rsp_tag_d;
    logic                    last_grant_q, last_grant_d;

    logic [1:0]              elig_c;
    logic [1:0]              grant_c;
    logic                    gsel_c;
    logic [DATA_W-1:0]       alu_res_c;

    // A port may reissue in the same cycle its held result is consumed.
    assign elig_c = req_valid & (~rsp_valid_q | rsp_ready);

    alu_rr_pick u_pick (
        .elig       (elig_c),
        .last_grant (last_grant_q),
        .prio0      (PRIO0),
        .grant      (grant_c)
    );

    assign gsel_c    = grant_c[1];
    assign alu_res_c = alu_eval(req_op[gsel_c], req_a[gsel_c], req_b[gsel_c], req_shamt[gsel_c]);
    assign req_ready = rst ? 2'b00 : grant_c;

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_tag_d    = rsp_tag_q;
        last_grant_d = last_grant_q;
        for (int i = 0; i < 2; i++) begin
            if (grant_c[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = alu_res_c;
                rsp_tag_d[i]   = req_tag[i];
            end else if (rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
        if (grant_c != 2'b00) begin
            last_grant_d = gsel_c;
        end
    end

    // last_grant resets to 1 so port 0 wins the first round-robin conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_tag_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_tag_q    <= rsp_tag_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_tag    = rsp_tag_q;
    assign last_grant = last_grant_q;

endmodule
